// File: rtl/axis_i2c_arbiter.sv
// Round-robin arbiter sharing one axis_i2c master between NUM_REQ AXI-Stream requesters.
// Optional watchdog on the WAIT states is enabled by defining I2C_ARB_TIMEOUT_EN.
module axis_i2c_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned AXIS_DW        = 16,
  parameter int unsigned I2C_DW         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk_i,
  input  logic                         arstn_i,
  input  logic [NUM_REQ-1:0]           s_tvalid_i,
  output logic [NUM_REQ-1:0]           s_tready_o,
  input  logic [NUM_REQ*AXIS_DW-1:0]   s_tdata_i,
  output logic                         m_tvalid_o,
  input  logic                         m_tready_i,
  output logic [AXIS_DW-1:0]           m_tdata_o,
  input  logic                         i2c_rvalid_i,
  input  logic [I2C_DW-1:0]            i2c_rdata_i,
  output logic [NUM_REQ-1:0]           rvalid_o,
  output logic [I2C_DW-1:0]            rdata_o,
  output logic [NUM_REQ-1:0]           grant_o,
  output logic                         busy_o,
  output logic                         timeout_o
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {ARB, SEND, WAIT_BUSY, WAIT_DONE} state_t;

  state_t               state, state_n;
  logic [PTR_W-1:0]     ptr, ptr_n, win;
  logic                 win_vld;
  logic [NUM_REQ-1:0]   grant_n;
  logic [AXIS_DW-1:0]   tdata_n;
  logic                 live;
  logic                 tmo_hit;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("axis_i2c_arbiter: parameter out of range");
  end

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int unsigned    CNT_W   = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt, cnt_n;

  // Watchdog counts from WAIT_BUSY entry; a completion in the limit cycle wins.
  always_comb begin
    cnt_n = cnt;
    if (state == SEND && m_tready_i)
      cnt_n = '0;
    else if (state == WAIT_BUSY || state == WAIT_DONE)
      cnt_n = cnt + CNT_W'(1);
  end

  assign tmo_hit = (cnt == CNT_MAX) &&
                   (state == WAIT_BUSY || (state == WAIT_DONE && !m_tready_i));

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      cnt       <= '0;
      timeout_o <= 1'b0;
    end else begin
      cnt       <= cnt_n;
      timeout_o <= tmo_hit;
    end
  end
`else
  assign tmo_hit   = 1'b0;
  assign timeout_o = 1'b0;
`endif

  // Round-robin search starting just after the last owner.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx     = '0;
    win     = '0;
    win_vld = 1'b0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = PTR_W'((32'(ptr) + i) % NUM_REQ);
      if (!win_vld && s_tvalid_i[idx]) begin
        win_vld = 1'b1;
        win     = idx;
      end
    end
  end

  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    grant_n    = grant_o;
    tdata_n    = m_tdata_o;
    s_tready_o = '0;
    rvalid_o   = '0;
    rdata_o    = '0;
    unique case (state)
      ARB: begin
        if (live && win_vld) begin
          s_tready_o = NUM_REQ'(1) << win;
          grant_n    = NUM_REQ'(1) << win;
          tdata_n    = s_tdata_i[32'(win)*AXIS_DW +: AXIS_DW];
          ptr_n      = win;
          state_n    = SEND;
        end
      end
      SEND: begin
        if (m_tready_i) state_n = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tmo_hit) begin
          state_n = ARB;
          grant_n = '0;
        end else if (!m_tready_i) begin
          state_n = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        rdata_o = i2c_rdata_i;
        if (tmo_hit) begin
          state_n = ARB;
          grant_n = '0;
        end else begin
          rvalid_o = grant_o & {NUM_REQ{i2c_rvalid_i}};
          if (m_tready_i) begin
            state_n = ARB;
            grant_n = '0;
          end
        end
      end
      default: state_n = ARB;
    endcase
  end

  // live holds off arbitration while reset is asserted so every output reads 0.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state     <= ARB;
      ptr       <= PTR_W'(NUM_REQ - 1);
      grant_o   <= '0;
      m_tdata_o <= '0;
      live      <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      grant_o   <= grant_n;
      m_tdata_o <= tdata_n;
      live      <= 1'b1;
    end
  end

  assign m_tvalid_o = (state == SEND);
  assign busy_o     = (state != ARB);

endmodule

// File: tb/tb_axis_i2c_arbiter.sv
// Directed bench for axis_i2c_arbiter: grant order, read routing, late arrivals, reset, watchdog.
module tb_axis_i2c_arbiter;
  localparam int unsigned NR  = 4;
  localparam int unsigned ADW = 16;
  localparam int unsigned IDW = 8;

  logic              clk_i = 1'b0;
  logic              arstn_i;
  logic [NR-1:0]     s_tvalid_i;
  logic [NR-1:0]     s_tready_o;
  logic [NR*ADW-1:0] s_tdata_i;
  logic              m_tvalid_o;
  logic              m_tready_i;
  logic [ADW-1:0]    m_tdata_o;
  logic              i2c_rvalid_i;
  logic [IDW-1:0]    i2c_rdata_i;
  logic [NR-1:0]     rvalid_o;
  logic [IDW-1:0]    rdata_o;
  logic [NR-1:0]     grant_o;
  logic              busy_o;
  logic              timeout_o;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk_i = ~clk_i;

  axis_i2c_arbiter #(
    .NUM_REQ(NR), .AXIS_DW(ADW), .I2C_DW(IDW), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i(clk_i), .arstn_i(arstn_i),
    .s_tvalid_i(s_tvalid_i), .s_tready_o(s_tready_o), .s_tdata_i(s_tdata_i),
    .m_tvalid_o(m_tvalid_o), .m_tready_i(m_tready_i), .m_tdata_o(m_tdata_o),
    .i2c_rvalid_i(i2c_rvalid_i), .i2c_rdata_i(i2c_rdata_i),
    .rvalid_o(rvalid_o), .rdata_o(rdata_o), .grant_o(grant_o),
    .busy_o(busy_o), .timeout_o(timeout_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_word(input int k, input logic [ADW-1:0] w);
    s_tdata_i[k*ADW +: ADW] = w;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "/grant"},  32'(grant_o),    32'h0);
    chk({tag, "/busy"},   32'(busy_o),     32'h0);
    chk({tag, "/mvalid"}, 32'(m_tvalid_o), 32'h0);
    chk({tag, "/mdata"},  32'(m_tdata_o),  32'h0);
    chk({tag, "/tready"}, 32'(s_tready_o), 32'h0);
    chk({tag, "/rvalid"}, 32'(rvalid_o),   32'h0);
    chk({tag, "/rdata"},  32'(rdata_o),    32'h0);
    chk({tag, "/tmo"},    32'(timeout_o),  32'h0);
  endtask

  // Entered in ARB one tick after an edge, with the requester's tvalid already driven.
  task automatic serve(input string tag, input int k, input logic [ADW-1:0] w,
                       input bit rd, input logic [IDW-1:0] rbyte);
    logic [NR-1:0] oh;
    oh = NR'(1) << k;
    #1 chk({tag, "/tready"}, 32'(s_tready_o), 32'(oh));
    step();
    chk({tag, "/mvalid"},    32'(m_tvalid_o), 32'h1);
    chk({tag, "/mdata"},     32'(m_tdata_o),  32'(w));
    chk({tag, "/grant"},     32'(grant_o),    32'(oh));
    chk({tag, "/tready_tx"}, 32'(s_tready_o), 32'h0);
    step();
    chk({tag, "/mvalid_off"}, 32'(m_tvalid_o), 32'h0);
    m_tready_i = 1'b0;
    step();
    i2c_rvalid_i = rd;
    i2c_rdata_i  = rbyte;
    #1 chk({tag, "/rvalid"}, 32'(rvalid_o), rd ? 32'(oh) : 32'h0);
    if (rd) chk({tag, "/rdata"}, 32'(rdata_o), 32'(rbyte));
    step();
    i2c_rvalid_i = 1'b0;
    m_tready_i   = 1'b1;
    step();
    chk({tag, "/grant_rel"}, 32'(grant_o), 32'h0);
    chk({tag, "/busy_rel"},  32'(busy_o),  32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    arstn_i      = 1'b0;
    s_tvalid_i   = '0;
    s_tdata_i    = '0;
    m_tready_i   = 1'b1;
    i2c_rvalid_i = 1'b0;
    i2c_rdata_i  = '0;
    #12 chk_all_zero("reset");
    @(posedge clk_i); #1 arstn_i = 1'b1;
    step();

    // Single request from req0 right after reset.
    set_word(0, 16'hA550);
    s_tvalid_i = 4'b0001;
    serve("t1", 0, 16'hA550, 1'b0, 8'h00);
    s_tvalid_i = '0;

    // Fresh reset, then all four requesting: order 0,1,2,3, then wrap to req0.
    arstn_i = 1'b0;
    #1 chk("t2_rst/grant", 32'(grant_o), 32'h0);
    step(); arstn_i = 1'b1; step();
    for (int k = 0; k < 4; k++) set_word(k, 16'(16'h1100 * (k + 1) + k));
    s_tvalid_i = 4'b1111;
    for (int k = 0; k < 4; k++) serve("t2_rr", k, 16'(16'h1100 * (k + 1) + k), 1'b0, 8'h00);
    s_tvalid_i = 4'b0101;
    serve("t2_wrap", 0, 16'h1100, 1'b0, 8'h00);
    s_tvalid_i = '0;

    // Read by req1 routed to req1 only.
    set_word(1, 16'h00A1);
    s_tvalid_i = 4'b0010;
    serve("t3", 1, 16'h00A1, 1'b1, 8'h3C);
    s_tvalid_i = '0;

    // Master read pulse while idle must not reach anyone.
    i2c_rvalid_i = 1'b1;
    i2c_rdata_i  = 8'h77;
    #1 chk("idle_rv/rvalid", 32'(rvalid_o), 32'h0);
    chk("idle_rv/rdata", 32'(rdata_o), 32'h0);
    step();
    i2c_rvalid_i = 1'b0;

    // req3 arrives during req0's WAIT_DONE and waits for the next ARB cycle.
    set_word(0, 16'h5A51);
    set_word(3, 16'hC3C3);
    s_tvalid_i = 4'b0001;
    #1 chk("t4/tready0", 32'(s_tready_o), 32'h1);
    step();
    s_tvalid_i = '0;
    chk("t4/grant0", 32'(grant_o), 32'h1);
    step();
    m_tready_i = 1'b0;
    step();
    s_tvalid_i = 4'b1000;
    #1 chk("t4/hold_a", 32'(s_tready_o), 32'h0);
    step();
    m_tready_i = 1'b1;
    #1 chk("t4/hold_b", 32'(s_tready_o), 32'h0);
    step();
    #1 chk("t4/tready3", 32'(s_tready_o), 32'h8);
    chk("t4/busy_arb", 32'(busy_o), 32'h0);
    step();
    s_tvalid_i = '0;
    chk("t4/grant3", 32'(grant_o), 32'h8);
    chk("t4/mdata3", 32'(m_tdata_o), 32'hC3C3);
    step();
    m_tready_i = 1'b0;
    step();

    // Reset asserted while req3 sits in WAIT_DONE.
    i2c_rvalid_i = 1'b1;
    i2c_rdata_i  = 8'h99;
    s_tvalid_i   = 4'b1001;
    #1 chk("t5/rvalid_pre", 32'(rvalid_o), 32'h8);
    arstn_i = 1'b0;
    #1 chk_all_zero("t5_rst");
    i2c_rvalid_i = 1'b0;
    m_tready_i   = 1'b1;
    step();
    arstn_i = 1'b1;
    step();
    serve("t5", 0, 16'h5A51, 1'b0, 8'h00);
    s_tvalid_i = '0;

`ifdef I2C_ARB_TIMEOUT_EN
    // Master never returns to idle: watchdog fires 16 cycles after WAIT_BUSY entry.
    s_tvalid_i = 4'b0010;
    #1 chk("t6/tready", 32'(s_tready_o), 32'h2);
    step();
    s_tvalid_i = '0;
    step();
    m_tready_i = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      step();
      chk("t6/no_tmo", 32'(timeout_o), 32'h0);
    end
    step();
    chk("t6/tmo",   32'(timeout_o), 32'h1);
    chk("t6/grant", 32'(grant_o),   32'h0);
    chk("t6/busy",  32'(busy_o),    32'h0);
    step();
    chk("t6/tmo_end", 32'(timeout_o), 32'h0);
    m_tready_i = 1'b1;
`else
    // Without the watchdog a stuck master keeps the arbiter waiting.
    s_tvalid_i = 4'b0010;
    #1 chk("t6/tready", 32'(s_tready_o), 32'h2);
    step();
    s_tvalid_i = '0;
    step();
    m_tready_i = 1'b0;
    for (int i = 0; i < 40; i++) step();
    chk("t6/busy_hold",  32'(busy_o),    32'h1);
    chk("t6/grant_hold", 32'(grant_o),   32'h2);
    chk("t6/no_tmo",     32'(timeout_o), 32'h0);
    m_tready_i = 1'b1;
    step();
    chk("t6/done", 32'(busy_o), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
